// File: rtl/minx_bus_responder.sv
// minx_bus_responder: S1C88 memory bus target.
// Decodes core cycles into internal RAM, peripheral registers or the cartridge port.
module minx_bus_responder #(
   parameter int          RAM_ADDR_WIDTH = 12,
   parameter logic [23:0] RAM_BASE       = 24'h001000,
   parameter logic [23:0] REG_BASE       = 24'h002000,
   parameter int          CART_TIMEOUT   = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pl,
   input  logic [23:0] address_in,
   input  logic [1:0]  bus_status,
   input  logic [7:0]  cpu_wdata,
   input  logic [7:0]  irq_vector,
   output logic [7:0]  cpu_rdata,
   output logic        bus_wait,
   output logic        bus_error,
   output logic [7:0]  reg_addr,
   output logic [7:0]  reg_wdata,
   output logic        reg_we,
   output logic        reg_re,
   input  logic [7:0]  reg_rdata,
   output logic [23:0] cart_addr,
   output logic [7:0]  cart_wdata,
   output logic        cart_we,
   output logic        cart_req,
   input  logic        cart_ack,
   input  logic [7:0]  cart_rdata
);

   localparam logic [1:0]  ST_IRQ = 2'd1;
   localparam logic [1:0]  ST_WR  = 2'd2;
   localparam logic [1:0]  ST_RD  = 2'd3;
   localparam logic [3:0]  LP_TO  = 4'(CART_TIMEOUT);
   localparam logic [24:0] LP_REG_END = {1'b0, REG_BASE} + 25'd256;
   localparam int          LP_DEPTH = 1 << RAM_ADDR_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RAM,
      S_REG,
      S_CART
   } state_t;

   state_t r_state, w_state_n;

   logic [7:0]                r_ram [LP_DEPTH];
   logic [RAM_ADDR_WIDTH-1:0] r_idx, w_idx_n;
   logic                      r_is_wr, w_is_wr_n;
   logic [7:0]                r_wdata, w_wdata_n;
   logic [7:0]                r_rdata, w_rdata_n;
   logic                      r_err, w_err_n;
   logic                      r_re, w_re_n;
   logic                      r_we, w_we_n;
   logic [7:0]                r_reg_addr, w_reg_addr_n;
   logic [7:0]                r_reg_wdata, w_reg_wdata_n;
   logic                      r_busy, w_busy_n;
   logic [3:0]                r_cnt, w_cnt_n;
   logic [23:0]               r_caddr, w_caddr_n;
   logic [7:0]                r_cwdata, w_cwdata_n;
   logic                      r_cwe, w_cwe_n;
   logic                      w_ram_we;

   logic                      w_cap;
   logic                      w_wr;
   logic                      w_unmapped;
   logic                      w_is_ram;
   logic                      w_is_reg;
   logic [3:0]                w_cnt_inc;
   logic [RAM_ADDR_WIDTH-1:0] w_ram_idx;

   assign w_cap      = pl && (bus_status != 2'd0);
   assign w_wr       = (bus_status == ST_WR);
   assign w_unmapped = (address_in < RAM_BASE);
   assign w_is_ram   = !w_unmapped && (address_in < REG_BASE);
   assign w_is_reg   = !w_unmapped && !w_is_ram &&
                       ({1'b0, address_in} < LP_REG_END);
   assign w_cnt_inc  = r_cnt + 4'd1;
   // Offset from RAM_BASE, wrapping inside the RAM depth.
   assign w_ram_idx  = address_in[RAM_ADDR_WIDTH-1:0]
                     - RAM_BASE[RAM_ADDR_WIDTH-1:0];

   // Next-state and next-output logic for the bus FSM.
   always_comb begin
      w_state_n     = r_state;
      w_idx_n       = r_idx;
      w_is_wr_n     = r_is_wr;
      w_wdata_n     = r_wdata;
      w_rdata_n     = r_rdata;
      w_err_n       = 1'b0;
      w_re_n        = 1'b0;
      w_we_n        = 1'b0;
      w_reg_addr_n  = r_reg_addr;
      w_reg_wdata_n = r_reg_wdata;
      w_busy_n      = r_busy;
      w_cnt_n       = r_cnt;
      w_caddr_n     = r_caddr;
      w_cwdata_n    = r_cwdata;
      w_cwe_n       = r_cwe;
      w_ram_we      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_cap) begin
               if (bus_status == ST_IRQ) begin
                  w_rdata_n = irq_vector;
               end else if (w_unmapped) begin
                  w_err_n = 1'b1;
                  if (bus_status == ST_RD) w_rdata_n = 8'hFF;
               end else if (w_is_ram) begin
                  w_state_n = S_RAM;
                  w_idx_n   = w_ram_idx;
                  w_is_wr_n = w_wr;
                  w_wdata_n = cpu_wdata;
               end else if (w_is_reg) begin
                  w_state_n    = S_REG;
                  w_reg_addr_n = address_in[7:0];
                  w_re_n       = !w_wr;
                  w_we_n       = w_wr;
                  if (w_wr) w_reg_wdata_n = cpu_wdata;
               end else begin
                  w_state_n  = S_CART;
                  w_caddr_n  = address_in;
                  w_cwdata_n = cpu_wdata;
                  w_cwe_n    = w_wr;
                  w_busy_n   = 1'b1;
                  w_cnt_n    = 4'd0;
               end
            end
         end
         S_RAM: begin
            w_err_n   = w_cap;
            w_state_n = S_IDLE;
            if (r_is_wr) w_ram_we = 1'b1;
            else         w_rdata_n = r_ram[r_idx];
         end
         S_REG: begin
            w_err_n   = w_cap;
            w_state_n = S_IDLE;
            if (r_re) w_rdata_n = reg_rdata;
         end
         S_CART: begin
            w_err_n = w_cap;
            if (cart_ack) begin
               w_state_n = S_IDLE;
               w_busy_n  = 1'b0;
               w_cnt_n   = 4'd0;
               w_cwe_n   = 1'b0;
               if (!r_cwe) w_rdata_n = cart_rdata;
            end else if (w_cnt_inc == LP_TO) begin
               w_state_n = S_IDLE;
               w_busy_n  = 1'b0;
               w_cnt_n   = 4'd0;
               w_cwe_n   = 1'b0;
               w_err_n   = 1'b1;
               if (!r_cwe) w_rdata_n = 8'hFF;
            end else begin
               w_cnt_n = w_cnt_inc;
            end
         end
         default: w_state_n = S_IDLE;
      endcase
   end

   // Register the FSM state and all bus-facing outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_is_wr     <= 1'b0;
         r_wdata     <= 8'h00;
         r_rdata     <= 8'hFF;
         r_err       <= 1'b0;
         r_re        <= 1'b0;
         r_we        <= 1'b0;
         r_reg_addr  <= 8'h00;
         r_reg_wdata <= 8'h00;
         r_busy      <= 1'b0;
         r_cnt       <= 4'd0;
         r_caddr     <= 24'h0;
         r_cwdata    <= 8'h00;
         r_cwe       <= 1'b0;
      end else begin
         r_state     <= w_state_n;
         r_idx       <= w_idx_n;
         r_is_wr     <= w_is_wr_n;
         r_wdata     <= w_wdata_n;
         r_rdata     <= w_rdata_n;
         r_err       <= w_err_n;
         r_re        <= w_re_n;
         r_we        <= w_we_n;
         r_reg_addr  <= w_reg_addr_n;
         r_reg_wdata <= w_reg_wdata_n;
         r_busy      <= w_busy_n;
         r_cnt       <= w_cnt_n;
         r_caddr     <= w_caddr_n;
         r_cwdata    <= w_cwdata_n;
         r_cwe       <= w_cwe_n;
      end
   end

   // RAM array; contents survive reset.
   always_ff @(posedge clk) begin
      if (w_ram_we) r_ram[r_idx] <= r_wdata;
   end

   assign cpu_rdata  = r_rdata;
   assign bus_wait   = r_busy;
   assign cart_req   = r_busy;
   assign bus_error  = r_err;
   assign reg_addr   = r_reg_addr;
   assign reg_wdata  = r_reg_wdata;
   assign reg_we     = r_we;
   assign reg_re     = r_re;
   assign cart_addr  = r_caddr;
   assign cart_wdata = r_cwdata;
   assign cart_we    = r_cwe;

endmodule
